segasys_hiscore_bridge: RTL
===========================

// Module: segasys_hiscore_bridge
// PURPOSE
//  Parametrised hiscore access bridge between the external hiscore engine and NREG
//  on-chip RAM regions (main work RAM, video RAM, sprite RAM, ...).
//  Sequences a pause handshake: halts the game with PAUSE_N, waits for bus settle,
//  grants access, then decodes strobes to the matching region with pipelined readback.
//  Sits in the system top between the HS* ports and the main/video sub-blocks.
// PARAMETERS
//  NREG     4                    number of RAM regions decoded
//  AW       16                   hiscore address width
//  RD_LAT   2                    region read latency in cycles (1..4)
//  SETTLE   8                    cycles PAUSE_N held low before grant (>=1)
//  REG_BASE {16'hC000,16'hD000,16'hE000,16'hF000}  packed NREG*AW region base addresses
//  REG_MASK {4{16'hF000}}        packed NREG*AW compare masks
// PORTS
//  clk40M       in   1         system clock
//  reset        in   1         asynchronous, active-high reset
//  hs_req       in   1         engine requests access window (level)
//  hs_ack       out  1         window granted (level)
//  hs_stb       in   1         one-cycle access strobe, honoured only while hs_ack=1
//  hs_we        in   1         1=write, 0=read; sampled with hs_stb
//  hs_ad        in   AW        access address; sampled with hs_stb
//  hs_di        in   8         write data; sampled with hs_stb
//  hs_do        out  8         read data; valid when hs_dv=1
//  hs_dv        out  1         one-cycle read-data-valid pulse
//  hs_miss      out  1         one-cycle pulse: strobe address matched no region
//  pause_user_n in   1         user pause (active low), merged into PAUSE_N
//  PAUSE_N      out  1         registered halt to main/video/sound (0=halted)
//  sub_ad       out  AW        address to all regions
//  sub_di       out  8         write data to all regions
//  sub_we       out  NREG      per-region one-cycle write enable
//  sub_do       in   NREG*8    per-region read data, valid RD_LAT cycles after sub_ad
// BEHAVIOUR
//  Reset: state IDLE; hs_ack=0, hs_dv=0, hs_miss=0, hs_do=0, sub_we=0, sub_ad=0,
//   sub_di=0, PAUSE_N=1, settle counter=0, read pipeline cleared.
//  PAUSE_N (registered) = pause_user_n & (state==IDLE); 1-cycle delay from inputs.
//  FSM: IDLE -> HALT when hs_req=1; HALT counts SETTLE cycles, then -> GRANT.
//   GRANT: hs_ack=1; hs_req=0 -> DRAIN. DRAIN: hs_ack=0; waits until read pipeline
//   empty, then -> IDLE. hs_req dropping in HALT aborts directly to IDLE, no ack.
//  Decode: region i hits when (hs_ad & MASK_i)==(BASE_i & MASK_i); lowest i wins.
//  Write strobe: next cycle sub_ad/sub_di loaded, sub_we[i]=1 for exactly one cycle.
//   No hit: sub_we stays 0, hs_miss pulses next cycle.
//  Read strobe: sub_ad loaded next cycle; region index carried through an RD_LAT-deep
//   shift pipeline; hs_dv pulses and hs_do=sub_do[i] exactly RD_LAT+1 cycles after
//   hs_stb. No hit: hs_dv still pulses at same latency, hs_do=8'hFF, hs_miss pulses.
//  Back-to-back strobes every cycle accepted; reads fully pipelined, order preserved.
//  hs_stb while hs_ack=0 ignored (no sub_we, no hs_dv, no hs_miss).
//  Reads in flight when hs_req falls still complete (hs_dv delivered) before IDLE.
//  Asynchronous reset mid-window: all outputs to reset values immediately,
//   in-flight reads discarded, PAUSE_N returns to 1.
//  sub_ad holds last value when idle; sub_di only updated on write strobes.
// TESTING
//  Reset then hs_req=1 at cycle 0 -> PAUSE_N=0 at cycle 1, hs_ack=1 at cycle 1+SETTLE.
//  Grant, write 8'h5A to 16'hD123 -> sub_we=4'b0010 one cycle, sub_ad=16'hD123, sub_di=8'h5A.
//  Grant, reads 16'hC010,16'hE020 on consecutive cycles, sub_do C=8'h11,E=8'h22
//   -> hs_dv on cycles stb+3, stb+4 with hs_do 8'h11 then 8'h22 (RD_LAT=2).
//  Read 16'h1234 (no region) -> hs_miss pulse, hs_dv at stb+3 with hs_do=8'hFF.
//  Drop hs_req the cycle after a read strobe -> hs_ack=0, hs_dv still delivered, then
//   PAUSE_N=1; pause_user_n=0 in IDLE -> PAUSE_N=0 one cycle later, hs_ack stays 0.
//  Assert reset in GRANT with read in flight -> hs_ack=0, PAUSE_N=1, no hs_dv after release.

Source files
------------

// File: rtl/segasys_hiscore_bridge.sv
// segasys_hiscore_bridge
// Hiscore access bridge between the external hiscore engine and NREG on-chip
// RAM regions. It halts the game with PAUSE_N, waits for the bus to settle,
// grants the window, then decodes strobes to the matching region. Reads are
// pipelined and return in order.
//
// Handshake: hs_stb is a one-cycle valid and hs_ack acts as ready. A transfer
// happens only on a cycle where both are 1. hs_ack never drops in the middle
// of a cycle, so a strobe is either fully accepted or fully ignored.
//
// Region ordering: REG_BASE and REG_MASK list region 0 first, so region 0
// sits in the most significant AW bits. sub_we[i] and sub_do[i*8 +: 8]
// belong to region i, with region 0 in the least significant position.
module segasys_hiscore_bridge #(
    parameter int NREG   = 4,
    parameter int AW     = 16,
    parameter int RD_LAT = 2,
    parameter int SETTLE = 8,
    parameter logic [NREG*AW-1:0] REG_BASE = {16'hC000, 16'hD000, 16'hE000, 16'hF000},
    parameter logic [NREG*AW-1:0] REG_MASK = {4{16'hF000}}
) (
    input  logic              clk40M,
    input  logic              reset,
    input  logic              hs_req,
    output logic              hs_ack,
    input  logic              hs_stb,
    input  logic              hs_we,
    input  logic [AW-1:0]     hs_ad,
    input  logic [7:0]        hs_di,
    output logic [7:0]        hs_do,
    output logic              hs_dv,
    output logic              hs_miss,
    input  logic              pause_user_n,
    output logic              PAUSE_N,
    output logic [AW-1:0]     sub_ad,
    output logic [7:0]        sub_di,
    output logic [NREG-1:0]   sub_we,
    input  logic [NREG*8-1:0] sub_do,
    output logic [1:0]        dbg_state
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, HALT = 2'd1, GRANT = 2'd2, DRAIN = 2'd3} state_t;

    state_t          state;
    logic [CW-1:0]   settle_cnt;
    logic            acc;
    logic            hit;
    logic [IW-1:0]   hit_idx;
    logic            next_idle;
    logic            pipe_busy;
    logic [7:0]      rd_sel;
    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_hit;
    logic [IW-1:0]   pipe_idx [RD_LAT];

    assign acc       = hs_stb & hs_ack;
    assign pipe_busy = |pipe_v;
    assign dbg_state = state;

    // Address decode: scan from the top so the lowest matching region wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((hs_ad & REG_MASK[(NREG-1-i)*AW +: AW]) ==
                (REG_BASE[(NREG-1-i)*AW +: AW] & REG_MASK[(NREG-1-i)*AW +: AW])) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Next-state-is-IDLE, so PAUSE_N releases on the same edge the FSM returns to IDLE.
    always_comb begin
        next_idle = 1'b0;
        case (state)
            IDLE:    next_idle = !hs_req;
            HALT:    next_idle = !hs_req;
            GRANT:   next_idle = 1'b0;
            DRAIN:   next_idle = !pipe_busy;
            default: next_idle = 1'b1;
        endcase
    end

    // Read-data mux for the region at the end of the read pipeline.
    always_comb begin
        rd_sel = 8'h00;
        for (int i = 0; i < NREG; i++) begin
            if (pipe_idx[RD_LAT-1] == IW'(i)) rd_sel = sub_do[i*8 +: 8];
        end
    end

    // Access-window FSM: halt the game, settle, grant, then drain outstanding reads.
    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            hs_ack     <= 1'b0;
            PAUSE_N    <= 1'b1;
        end else begin
            PAUSE_N <= pause_user_n & next_idle;
            case (state)
                IDLE: begin
                    settle_cnt <= '0;
                    if (hs_req) state <= HALT;
                end
                HALT: begin
                    if (!hs_req) begin
                        state      <= IDLE;
                        settle_cnt <= '0;
                    end else if (settle_cnt == CW'(SETTLE - 1)) begin
                        state      <= GRANT;
                        settle_cnt <= '0;
                        hs_ack     <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                GRANT: begin
                    if (!hs_req) begin
                        state  <= DRAIN;
                        hs_ack <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    hs_ack <= 1'b0;
                end
            endcase
        end
    end

    // Strobe launch: drive the shared address/data bus and the one-hot write enable.
    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            sub_ad  <= '0;
            sub_di  <= '0;
            sub_we  <= '0;
            hs_miss <= 1'b0;
        end else begin
            sub_we  <= '0;
            hs_miss <= acc & ~hit;
            if (acc) begin
                sub_ad <= hs_ad;
                if (hs_we) begin
                    sub_di <= hs_di;
                    if (hit) sub_we <= NREG'(1) << hit_idx;
                end
            end
        end
    end

    // Read pipeline: carry region index RD_LAT stages, then register the returned byte.
    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            pipe_v   <= '0;
            pipe_hit <= '0;
            for (int k = 0; k < RD_LAT; k++) pipe_idx[k] <= '0;
            hs_dv    <= 1'b0;
            hs_do    <= 8'h00;
        end else begin
            pipe_v[0]   <= acc & ~hs_we;
            pipe_hit[0] <= hit;
            pipe_idx[0] <= hit_idx;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_v[k]   <= pipe_v[k-1];
                pipe_hit[k] <= pipe_hit[k-1];
                pipe_idx[k] <= pipe_idx[k-1];
            end
            hs_dv <= pipe_v[RD_LAT-1];
            if (pipe_v[RD_LAT-1]) hs_do <= pipe_hit[RD_LAT-1] ? rd_sel : 8'hFF;
        end
    end

endmodule
